// File: rtl/phase_readout.sv
// Phase readout: synchronizes the diagonal-cell oscillator phases against a
// reference oscillator. It counts per-spin phase mismatches over a
// programmable window. At the end of the window it resolves one spin bit
// per oscillator by majority vote.
module phase_readout #(
  parameter int NUM_SPINS   = 8,
  parameter int COUNT_BITS  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  axi_rstn,
  input  logic [NUM_SPINS-1:0]  phase_in,
  input  logic                  ref_phase,
  input  logic                  start,
  input  logic                  clear,
  input  logic [COUNT_BITS-1:0] settle_cycles,
  input  logic [COUNT_BITS-1:0] window_cycles,
  output logic                  ising_rstn,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_SPINS-1:0]  spins,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic [COUNT_BITS-1:0] rd_count
);

  localparam int SW = NUM_SPINS + 1;
  localparam logic [COUNT_BITS-1:0] ONE     = COUNT_BITS'(1);
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [COUNT_BITS-1:0]   timer_reg, timer_next;
  logic [COUNT_BITS-1:0]   settle_lat_reg, window_lat_reg;
  logic                    ising_rstn_reg;
  logic [NUM_SPINS-1:0]    spins_reg;
  logic                    start_accept;
  logic                    last_run;
  logic                    count_en;

  // Synchronizer chain: the reference phase rides in the top bit alongside the spins.
  logic [SW-1:0]           sync_in;
  logic [SW-1:0]           sync_reg [SYNC_STAGES];
  logic [NUM_SPINS-1:0]    sync_phase;
  logic                    sync_ref;

  logic [COUNT_BITS-1:0]   count_vec      [NUM_SPINS];
  logic [COUNT_BITS-1:0]   count_next_vec [NUM_SPINS];
  logic [NUM_SPINS-1:0]    spin_win;

  assign sync_in    = {ref_phase, phase_in};
  assign sync_phase = sync_reg[SYNC_STAGES-1][NUM_SPINS-1:0];
  assign sync_ref   = sync_reg[SYNC_STAGES-1][NUM_SPINS];

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      // First synchronizer stage captures the raw asynchronous inputs.
      always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) sync_reg[gi] <= '0;
        else           sync_reg[gi] <= sync_in;
      end
    end else begin : g_next
      // Later stages resolve metastability from the previous stage.
      always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) sync_reg[gi] <= '0;
        else           sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) state_reg <= S_IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic. One timer is shared between settle and window phases.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    start_accept = 1'b0;
    last_run     = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          timer_next   = '0;
          state_next   = (settle_cycles != '0) ? S_SETTLE : S_RUN;
        end
      end
      S_SETTLE: begin
        if (timer_reg == settle_lat_reg - ONE) begin
          timer_next = '0;
          state_next = S_RUN;
        end else begin
          timer_next = timer_reg + ONE;
        end
      end
      S_RUN: begin
        // A zero window still spends one cycle here, but nothing is counted.
        if ((window_lat_reg == '0) || (timer_reg == window_lat_reg - ONE)) begin
          last_run   = 1'b1;
          timer_next = '0;
          state_next = S_DONE;
        end else begin
          timer_next = timer_reg + ONE;
        end
      end
      S_DONE: begin
        if (clear) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control registers: latched run parameters, timer, oscillator enable, spins.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      timer_reg      <= '0;
      settle_lat_reg <= '0;
      window_lat_reg <= '0;
      ising_rstn_reg <= 1'b0;
      spins_reg      <= '0;
    end else begin
      timer_reg      <= timer_next;
      ising_rstn_reg <= (state_next != S_IDLE);
      if (start_accept) begin
        settle_lat_reg <= settle_cycles;
        window_lat_reg <= window_cycles;
        spins_reg      <= '0;
      end else if (last_run) begin
        spins_reg      <= spin_win;
      end
    end
  end

  assign count_en = (state_reg == S_RUN) && (window_lat_reg != '0);

  for (genvar gi = 0; gi < NUM_SPINS; gi++) begin : g_spin
    logic [COUNT_BITS-1:0] cnt_reg, cnt_next;

    // Saturating mismatch counter for this spin.
    always_comb begin
      cnt_next = cnt_reg;
      if (start_accept)
        cnt_next = '0;
      else if (count_en && (sync_phase[gi] != sync_ref) && (cnt_reg != CNT_MAX))
        cnt_next = cnt_reg + ONE;
    end

    // Mismatch count register.
    always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) cnt_reg <= '0;
      else           cnt_reg <= cnt_next;
    end

    assign count_vec[gi]      = cnt_reg;
    assign count_next_vec[gi] = cnt_next;
  end

  // Majority vote on the count including the final window cycle; ties resolve to 0.
  always_comb begin
    spin_win = '0;
    for (int i = 0; i < NUM_SPINS; i++)
      spin_win[i] = ({count_next_vec[i], 1'b0} > {1'b0, window_lat_reg});
  end

  // Readback mux; out-of-range indices read as zero.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_SPINS; i++)
      if (rd_idx == IDX_BITS'(i)) rd_count = count_vec[i];
  end

  assign ising_rstn = ising_rstn_reg;
  assign busy       = (state_reg == S_SETTLE) || (state_reg == S_RUN);
  assign done       = (state_reg == S_DONE);
  assign spins      = spins_reg;

endmodule

// File: doc/phase_readout.md
Name: phase_readout

Overview:
- Sits directly downstream of the coupled-cell array. Owns the oscillator reset `ising_rstn` and samples the asynchronous diagonal-cell phase outputs against a reference oscillator.
- Counts per-spin phase mismatches over a programmable window, then resolves one spin bit per oscillator.
- The AXI register layer drives start/clear and reads back counts and spins.

Parameters:
- NUM_SPINS, 8, number of oscillators sampled (width of phase_in).
- COUNT_BITS, 16, width of window, settle and mismatch counters.
- SYNC_STAGES, 2, flops in each input synchronizer (minimum 2).
- IDX_BITS, 3, width of rd_idx (must satisfy 2^IDX_BITS >= NUM_SPINS).

Ports:
- clk  in  1  system clock.
- axi_rstn  in  1  reset, asynchronous, active-low.
- phase_in  in  NUM_SPINS  asynchronous oscillator phases (dout of diagonal cells).
- ref_phase  in  1  asynchronous reference oscillator phase.
- start  in  1  single-cycle pulse, begins an anneal/measure run.
- clear  in  1  single-cycle pulse, returns from DONE to IDLE.
- settle_cycles  in  COUNT_BITS  cycles to run oscillators before sampling.
- window_cycles  in  COUNT_BITS  sampling window length.
- ising_rstn  out  1  oscillator-array enable (0 = held in reset).
- busy  out  1  high in SETTLE or RUN.
- done  out  1  high in DONE.
- spins  out  NUM_SPINS  resolved spin vector.
- rd_idx  in  IDX_BITS  count readback select.
- rd_count  out  COUNT_BITS  mismatch count of spin rd_idx.

Behaviour:
- Reset (async, axi_rstn=0):
  - FSM=IDLE, ising_rstn=0, busy=0, done=0, spins=0.
  - All counters and synchronizer flops are 0.
  - Takes effect immediately, including mid-run; no partial results are retained.
- Synchronizers:
  - Each phase_in bit and ref_phase passes through SYNC_STAGES flops.
  - Only synchronized values are used. Sample latency is SYNC_STAGES cycles.
- IDLE:
  - ising_rstn=0. clear is ignored.
  - On start: latch settle_cycles and window_cycles into internal registers, zero all mismatch counts and spins, set ising_rstn=1.
  - Go to SETTLE if latched settle>0, else RUN.
- SETTLE:
  - ising_rstn=1, busy=1.
  - Settle counter increments each cycle. After exactly settle cycles in SETTLE, go to RUN.
- RUN:
  - busy=1. RUN lasts exactly the latched window cycles.
  - Each RUN cycle, for every i: if sync_phase[i] != sync_ref, count[i] increments, saturating at all-ones.
  - After the last RUN cycle, go to DONE.
  - If latched window==0: the FSM spends one cycle in RUN with no counting, then goes to DONE; spins=0 and counts=0.
- DONE entry:
  - spins[i] = 1 iff 2*count[i] > window, computed at COUNT_BITS+1 width. A tie resolves to 0.
  - spins is registered and valid on the first cycle done=1.
- DONE:
  - done=1, ising_rstn remains 1 (oscillators keep running). spins and counts hold.
  - clear sends the FSM to IDLE, where ising_rstn=0, done=0, and spins and counts hold until the next start.
  - start in DONE is ignored.
- start or clear while busy: ignored. Latched window/settle values are unaffected by input changes mid-run.
- Simultaneous start and clear: start wins in IDLE, clear wins in DONE, both are ignored otherwise.
- Timing: with start at cycle T, ising_rstn rises at T+1 and RUN occupies cycles T+1+S .. T+S+W. done rises at T+1+S+W, where S and W are the latched values (W=0 behaves as W=1 for timing).
- rd_count:
  - Combinational mux of the registered counts.
  - rd_idx >= NUM_SPINS returns 0.
  - Counts are visible live during RUN.

Test Plan:
- Reset/idle: hold axi_rstn=0, then release -> ising_rstn=0, busy=0, done=0, spins=0, rd_count=0 for all idx. Pulse clear in IDLE -> no change.
- In-phase run: tie ref_phase=phase_in=0, settle=4, window=10, start at T -> ising_rstn=1 at T+1, busy T+1..T+14, done at T+15, spins=0x00, all counts 0.
- Anti-phase/majority: phase_in[0]=~ref, phase_in[1]=ref, and phase_in[2] mismatched for exactly 5 of window=10 cycles -> count0=10, count1=0, count2=5, spins[0]=1, spins[1]=0, spins[2]=0 (tie).
- Zero window/settle: settle=0, window=0, start -> one RUN cycle with no counting, done at T+2, spins=0. Then clear -> IDLE, ising_rstn=0.
- Ignored controls: start during RUN and changing window_cycles mid-run -> timing and results match the originally latched values. start in DONE ignored, done stays 1.
- Reset mid-run: assert axi_rstn at RUN cycle 3 -> ising_rstn, busy, counts and spins go to 0 asynchronously. A subsequent start runs cleanly from zero. rd_idx=7 with NUM_SPINS=6 -> rd_count=0.
